// File: rtl/sram_axi_bridge_pkg.sv
// sram_axi_bridge_pkg
//   Shared definitions for the SRAM-like to AXI bridge and its helpers:
//   bridge FSM state encoding, AXI response/burst codes, SRAM size codes
//   and the ID value driven on arid/awid.
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4
    } bridge_state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [3:0] AXI_ID = 4'd0;

endpackage

// File: rtl/sram_axi_bridge_strb_gen.sv
// sram_strb_gen
//   Byte-lane strobe generator for 32-bit stores. Also usable by the data
//   cache for partial-word merges.
//   Ports:
//     size   in  2  SRAM size code (0 byte, 1 half, 2 word, 3 none)
//     offset in  2  addr[1:0] of the access
//     strb   out 4  byte-lane enables; size code 3 yields no lanes
module sram_strb_gen
    import sram_axi_bridge_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] offset,
    output logic [3:0] strb
);

    // Decode size and byte offset into lane enables; overflow past lane 3 is dropped
    always_comb begin
        strb = 4'b0000;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << offset;
            SIZE_HALF: strb = 4'b0011 << offset;
            SIZE_WORD: strb = 4'b1111;
            default:   strb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Single-outstanding bridge from the cache-side SRAM-like interface to a
//   32-bit AXI master. Every accepted request becomes one single-beat AXI
//   read (AR/R) or write (AW/W/B).
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     req/wr/size/addr/wdata    SRAM-like request (held until addr_ok)
//     rdata/addr_ok/data_ok     SRAM-like response (addr_ok/data_ok combinational)
//     ar*/r*                    AXI read address / read data channels
//     aw*/w*/b*                 AXI write address / write data / response channels
//     bus_err                   only when AXI_RESP_CHECK_EN is defined: pulses with
//                               data_ok when the completing rresp/bresp is not OKAY
//   Build option: AXI_RESP_CHECK_EN
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok,
`ifdef AXI_RESP_CHECK_EN
    output logic        bus_err,
`endif
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata_axi,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata_axi,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    bridge_state_e state_r;
    bridge_state_e state_s;
    logic [1:0]    size_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [3:0]    wstrb_r;
    logic [3:0]    wstrb_s;
    logic [31:0]   rdata_r;
    logic          aw_done_r;
    logic          w_done_r;
    logic          unused_s;

    sram_strb_gen u_strb_gen (
        .size   (size),
        .offset (addr[1:0]),
        .strb   (wstrb_s)
    );

    // State register, request capture and AW/W completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            size_r    <= 2'd0;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'b0000;
            rdata_r   <= 32'h0000_0000;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE && req) begin
                size_r  <= size;
                addr_r  <= addr;
                wdata_r <= wdata;
                wstrb_r <= wr ? wstrb_s : 4'b0000;
            end
            if (state_r == R && rvalid) begin
                rdata_r <= rdata_axi;
            end
            // Flags only live while both channels are open; any other state clears them
            if (state_r == AW_W) begin
                aw_done_r <= aw_done_r | (awvalid & awready);
                w_done_r  <= w_done_r  | (wvalid & wready);
            end else begin
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
            end
        end
    end

    // Next-state decode plus handshake outputs derived from the registered state
    always_comb begin
        state_s = state_r;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        rdata   = rdata_r;
        case (state_r)
            IDLE: begin
                addr_ok = req;
                if (req) begin
                    state_s = wr ? AW_W : AR;
                end else begin
                    state_s = IDLE;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_s = R;
                end else begin
                    state_s = AR;
                end
            end
            R: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_ok = 1'b1;
                    rdata   = rdata_axi;
                    state_s = IDLE;
                end else begin
                    state_s = R;
                end
            end
            AW_W: begin
                awvalid = ~aw_done_r;
                wvalid  = ~w_done_r;
                // A handshake in this very cycle counts as done
                if ((aw_done_r | awready) && (w_done_r | wready)) begin
                    state_s = B;
                end else begin
                    state_s = AW_W;
                end
            end
            B: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_ok = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = B;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign arid      = AXI_ID;
    assign araddr    = addr_r;
    assign arlen     = 8'd0;
    assign arsize    = {1'b0, size_r};
    assign arburst   = AXI_BURST_INCR;
    assign awid      = AXI_ID;
    assign awaddr    = addr_r;
    assign awlen     = 8'd0;
    assign awsize    = {1'b0, size_r};
    assign awburst   = AXI_BURST_INCR;
    assign wdata_axi = wdata_r;
    assign wstrb     = wstrb_r;
    assign wlast     = 1'b1;

`ifdef AXI_RESP_CHECK_EN
    // Flag a non-OKAY response on the beat that completes the transaction
    always_comb begin
        if (data_ok && state_r == R) begin
            bus_err = (rresp != AXI_RESP_OKAY);
        end else if (data_ok && state_r == B) begin
            bus_err = (bresp != AXI_RESP_OKAY);
        end else begin
            bus_err = 1'b0;
        end
    end
    // Single beat, single ID: these carry no information for this bridge
    assign unused_s = ^{rid, bid, rlast};
`else
    assign unused_s = ^{rid, bid, rlast, rresp, bresp};
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge
//   Directed and randomized bench for sram_axi_bridge. The bench plays both
//   the requester and the AXI slave; expectations come from transaction-level
//   rules (latency in cycles, byte-lane masks computed from byte ranges).
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        addr_ok, data_ok;
    logic [3:0]  arid, awid, rid, bid, wstrb;
    logic [31:0] araddr, awaddr, rdata_axi, wdata_axi;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef AXI_RESP_CHECK_EN
    logic        bus_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
`ifdef AXI_RESP_CHECK_EN
        .bus_err(bus_err),
`endif
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lanes covered by the byte range [base, base+nbytes); words ignore the offset
    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] m;
        int nb, base;
        m = 4'b0000;
        if (sz == 2'd3) return m;
        nb   = 1 << sz;
        base = (sz == 2'd2) ? 0 : int'(off);
        for (int b = 0; b < 4; b++) begin
            if (b >= base && b < base + nb) m[b] = 1'b1;
        end
        return m;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_valids"}, {arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok}, 7'd0);
        check({tag, "_araddr"}, araddr, 32'h0);
        check({tag, "_awaddr"}, awaddr, 32'h0);
        check({tag, "_wdata"}, wdata_axi, 32'h0);
        check({tag, "_wstrb"}, wstrb, 4'h0);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_sizes"}, {arsize, awsize}, 6'd0);
`ifdef AXI_RESP_CHECK_EN
        check({tag, "_bus_err"}, bus_err, 1'b0);
`endif
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input int ar_dly,
                           input int r_dly, input logic [31:0] d, input logic [1:0] resp,
                           input bit hold);
        req = 1'b1; wr = 1'b0; addr = a; size = sz;
        @(negedge clk);
        check("rd_t0_addr_ok", addr_ok, 1'b1);
        check("rd_t0_data_ok", data_ok, 1'b0);
        next_cycle();
        if (!hold) begin
            req = 1'b0; addr = $urandom; size = 2'(3 - sz);
        end
        for (int c = 0; c <= ar_dly; c++) begin
            arready = (c == ar_dly);
            @(negedge clk);
            check("rd_arvalid", arvalid, 1'b1);
            check("rd_araddr", araddr, a);
            check("rd_arsize", arsize, {1'b0, sz});
            check("rd_ar_fields", {arid, arlen, arburst}, {4'd0, 8'd0, 2'b01});
            check("rd_ar_rready", rready, 1'b0);
            check("rd_ar_oks", {addr_ok, data_ok}, 2'b00);
            next_cycle();
        end
        arready = 1'b0;
        for (int c = 0; c <= r_dly; c++) begin
            rvalid    = (c == r_dly);
            rdata_axi = rvalid ? d : $urandom;
            rresp     = resp;
            rid       = 4'($urandom);
            @(negedge clk);
            check("rd_rready", rready, 1'b1);
            check("rd_r_arvalid", arvalid, 1'b0);
            check("rd_data_ok", data_ok, rvalid);
            check("rd_r_addr_ok", addr_ok, 1'b0);
            if (rvalid) check("rd_rdata", rdata, d);
`ifdef AXI_RESP_CHECK_EN
            check("rd_bus_err", bus_err, rvalid && (resp != 2'b00));
`endif
            next_cycle();
        end
        rvalid = 1'b0; rresp = 2'b00;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] resp);
        bit aw_done, w_done;
        int last;
        req = 1'b1; wr = 1'b1; addr = a; size = sz; wdata = d;
        @(negedge clk);
        check("wr_t0_addr_ok", addr_ok, 1'b1);
        check("wr_t0_data_ok", data_ok, 1'b0);
        next_cycle();
        req = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom);
        aw_done = 1'b0; w_done = 1'b0;
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        for (int c = 0; c <= last; c++) begin
            awready = (c >= aw_dly);
            wready  = (c >= w_dly);
            @(negedge clk);
            check("wr_awvalid", awvalid, !aw_done);
            check("wr_wvalid", wvalid, !w_done);
            if (!aw_done) begin
                check("wr_awaddr", awaddr, a);
                check("wr_awsize", awsize, {1'b0, sz});
                check("wr_aw_fields", {awid, awlen, awburst}, {4'd0, 8'd0, 2'b01});
            end
            if (!w_done) begin
                check("wr_wdata", wdata_axi, d);
                check("wr_wstrb", wstrb, exp_strb(sz, a[1:0]));
                check("wr_wlast", wlast, 1'b1);
            end
            check("wr_aw_bready", bready, 1'b0);
            check("wr_aw_oks", {addr_ok, data_ok}, 2'b00);
            next_cycle();
            if (awready) aw_done = 1'b1;
            if (wready) w_done = 1'b1;
        end
        awready = 1'b0; wready = 1'b0;
        for (int c = 0; c <= b_dly; c++) begin
            bvalid = (c == b_dly);
            bresp  = resp;
            bid    = 4'($urandom);
            @(negedge clk);
            check("wr_bready", bready, 1'b1);
            check("wr_b_valids", {awvalid, wvalid}, 2'b00);
            check("wr_data_ok", data_ok, bvalid);
            check("wr_b_addr_ok", addr_ok, 1'b0);
`ifdef AXI_RESP_CHECK_EN
            check("wr_bus_err", bus_err, bvalid && (resp != 2'b00));
`endif
            next_cycle();
        end
        bvalid = 1'b0; bresp = 2'b00;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
        arready = 1'b0; rid = 4'd0; rdata_axi = 32'h0; rresp = 2'b00; rlast = 1'b1;
        rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'b00;
        bvalid = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        check_idle_outputs("reset");
        next_cycle();

        // Minimum-latency read
        do_read(32'h1FC0_0004, 2'd2, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0);
        // Slow slave on both read channels
        do_read(32'h0000_1230, 2'd1, 3, 2, 32'h1234_5678, 2'b00, 1'b0);
        // Byte and halfword stores
        do_write(32'h8000_0003, 2'd0, 32'hAB00_0000, 0, 0, 0, 2'b00);
        do_write(32'h8000_0002, 2'd1, 32'hCAFE_0000, 0, 0, 1, 2'b00);
        // W before AW, then AW before W, then word store with same-cycle handshakes
        do_write(32'h0000_0040, 2'd2, 32'h0102_0304, 2, 0, 1, 2'b00);
        do_write(32'h0000_0044, 2'd2, 32'h0506_0708, 0, 2, 0, 2'b00);
        do_write(32'h0000_0049, 2'd2, 32'h0A0B_0C0D, 1, 1, 2, 2'b00);
        // Size code 3 still completes, with no lanes enabled
        do_write(32'h0000_0050, 2'd3, 32'h5555_AAAA, 0, 1, 0, 2'b00);
        // Back-to-back reads with req held across the first transaction
        do_read(32'h0000_0100, 2'd2, 0, 0, 32'h1111_1111, 2'b00, 1'b1);
        do_read(32'h0000_0104, 2'd2, 1, 0, 32'h2222_2222, 2'b00, 1'b0);
        // Error responses
        do_write(32'h0000_0200, 2'd2, 32'hBADB_AD00, 0, 0, 0, 2'b10);
        do_read(32'h0000_0204, 2'd0, 0, 1, 32'h0000_00EE, 2'b11, 1'b0);

        // Reset while waiting in R
        req = 1'b1; wr = 1'b0; addr = 32'h0000_0300; size = 2'd2;
        next_cycle();
        req = 1'b0; arready = 1'b1;
        next_cycle();
        arready = 1'b0;
        @(negedge clk);
        check("rst_mid_in_r", rready, 1'b1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        next_cycle();
        do_read(32'h0000_0304, 2'd2, 0, 0, 32'h3333_4444, 2'b00, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rd;
            logic [1:0]  rs, rr;
            ra = $urandom;
            rd = $urandom;
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 1) == 0) begin
                rs = 2'($urandom_range(0, 2));
                do_read(ra, rs, $urandom_range(0, 3), $urandom_range(0, 3), rd, rr,
                        1'($urandom_range(0, 1)));
            end else begin
                rs = 2'($urandom_range(0, 3));
                do_write(ra, rs, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), rr);
            end
        end
        req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("final_quiet", {arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok}, 7'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
